serial_compare_ctrl: RTL



---
 rtl/compare_pkg.sv | 24 ++
 rtl/cmp4_slice.sv | 21 ++
 rtl/serial_compare_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// Shared encodings for the serial magnitude comparator: result codes, controller
// states and the cascade-in normalisation applied when an operation is accepted.
package compare_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } stateT;

    // Anything that is not a clean GT or LT code is treated as "no opinion yet".
    function automatic logic [2:0] normaliseCascade(input logic [2:0] code);
        case (code)
            CMP_GT:  return CMP_GT;
            CMP_LT:  return CMP_LT;
            default: return CMP_EQ;
        endcase
    endfunction

endpackage

// File: rtl/cmp4_slice.sv
// Combinational 4-bit cascadable magnitude comparator slice: an unequal nibble
// decides the result, an equal nibble passes the cascade-in through.
module cmp4_slice
    import compare_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] cascadeIn,
    output logic [2:0] result
);

    always_comb begin
        result = cascadeIn;
        if (a > b) begin
            result = CMP_GT;
        end else if (a < b) begin
            result = CMP_LT;
        end
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer that walks one cmp4_slice over two captured WIDTH-bit operands,
// LSB nibble first, carrying each slice result forward as the next cascade-in.
module serial_compare_ctrl
    import compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    stateT            state;
    stateT            nextState;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [2:0]       cascade;
    logic [3:0]       nibA;
    logic [3:0]       nibB;
    logic [2:0]       sliceResult;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (iStart) nextState = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) nextState = S_DONE;
            S_DONE:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // The slice only ever sees the nibble pair selected by the step counter.
    always_comb begin
        nibA = aReg[{cnt, 2'b00} +: 4];
        nibB = bReg[{cnt, 2'b00} +: 4];
    end

    cmp4_slice uSlice (
        .a         (nibA),
        .b         (nibB),
        .cascadeIn (cascade),
        .result    (sliceResult)
    );

    // oData is only loaded on the final step, so it holds steady through RUN.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt     <= '0;
            aReg    <= '0;
            bReg    <= '0;
            cascade <= CMP_EQ;
            oData   <= CMP_EQ;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        aReg    <= iData_a;
                        bReg    <= iData_b;
                        cascade <= normaliseCascade(iData);
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    cascade <= sliceResult;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        oData <= sliceResult;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy = (state == S_RUN) || (state == S_DONE);
    assign oDone = (state == S_DONE);

endmodule
